// File: rtl/cdic_sector_scheduler.sv
// cdic_sector_scheduler: CD-i sector fetch scheduler.
// Sequences SEEK/PLAY/PAUSE/STOP commands against the 75 Hz sector tick and
// issues one fetch request per tick while playing. An unacknowledged request
// is held across ticks; ticks lost this way are overruns.
// Optional macro CDIC_SCHED_STATS_EN enables the saturating overrun counter
// on `missed`; without it `missed` reads 0.
module cdic_sector_scheduler #(
  parameter int unsigned SEEK_TICKS = 3,
  parameter int unsigned LBA_W      = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sector_tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LBA_W-1:0] cmd_lba,
  output logic             fetch_req,
  output logic [LBA_W-1:0] fetch_lba,
  input  logic             fetch_ack,
  output logic             sector_irq,
  output logic [LBA_W-1:0] cur_lba,
  output logic [1:0]       state,
  output logic [7:0]       missed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEKING = 2'd1,
    PLAYING = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_STOP  = 2'd0,
    OP_PLAY  = 2'd1,
    OP_SEEK  = 2'd2,
    OP_PAUSE = 2'd3
  } op_t;

  state_t           state_q, state_d;
  logic [LBA_W-1:0] cur_lba_q, cur_lba_d;
  logic [3:0]       seek_cnt_q, seek_cnt_d;
  logic             fetch_req_q, fetch_req_d;
  logic [LBA_W-1:0] fetch_lba_q, fetch_lba_d;
  logic             sector_irq_q, sector_irq_d;
`ifdef CDIC_SCHED_STATS_EN
  logic [7:0]       missed_q, missed_d;
`endif

  // Register all scheduler state; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_lba_q    <= '0;
      seek_cnt_q   <= '0;
      fetch_req_q  <= 1'b0;
      fetch_lba_q  <= '0;
      sector_irq_q <= 1'b0;
`ifdef CDIC_SCHED_STATS_EN
      missed_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_lba_q    <= cur_lba_d;
      seek_cnt_q   <= seek_cnt_d;
      fetch_req_q  <= fetch_req_d;
      fetch_lba_q  <= fetch_lba_d;
      sector_irq_q <= sector_irq_d;
`ifdef CDIC_SCHED_STATS_EN
      missed_q     <= missed_d;
`endif
    end
  end

  // Next-state: commands take priority over a coincident tick; the pending
  // request retires only on ack, independent of state changes.
  always_comb begin
    state_d      = state_q;
    cur_lba_d    = cur_lba_q;
    seek_cnt_d   = seek_cnt_q;
    fetch_req_d  = fetch_req_q & ~fetch_ack;
    fetch_lba_d  = fetch_lba_q;
    sector_irq_d = fetch_req_q & fetch_ack;
`ifdef CDIC_SCHED_STATS_EN
    missed_d     = missed_q;
`endif
    if (cmd_valid) begin
      case (op_t'(cmd_op))
        OP_STOP: state_d = IDLE;
        OP_PLAY: begin
          if (state_q == IDLE || state_q == PAUSED) state_d = PLAYING;
        end
        OP_SEEK: begin
          cur_lba_d  = cmd_lba;
          seek_cnt_d = 4'(SEEK_TICKS);
          state_d    = SEEKING;
        end
        OP_PAUSE: begin
          if (state_q == PLAYING) state_d = PAUSED;
        end
        default: ;
      endcase
    end else if (sector_tick) begin
      case (state_q)
        SEEKING: begin
          seek_cnt_d = seek_cnt_q - 4'd1;
          if (seek_cnt_q <= 4'd1) begin
            seek_cnt_d = '0;
            state_d    = PLAYING;
          end
        end
        PLAYING: begin
          cur_lba_d = cur_lba_q + LBA_W'(1);
          if (fetch_req_q && !fetch_ack) begin
`ifdef CDIC_SCHED_STATS_EN
            if (missed_q != 8'hFF) missed_d = missed_q + 8'd1;
`endif
          end else begin
            fetch_req_d = 1'b1;
            fetch_lba_d = cur_lba_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = 1'b1;
  assign fetch_req  = fetch_req_q;
  assign fetch_lba  = fetch_lba_q;
  assign sector_irq = sector_irq_q;
  assign cur_lba    = cur_lba_q;
  assign state      = state_q;
`ifdef CDIC_SCHED_STATS_EN
  assign missed     = missed_q;
`else
  assign missed     = '0;
`endif

endmodule

// File: tb/tb_cdic_sector_scheduler.sv
// Scoreboard bench for cdic_sector_scheduler: expected fetch addresses are
// queued as stimulus is issued; a negedge monitor pops them on each accepted
// fetch and checks the following sector_irq pulse.
module tb_cdic_sector_scheduler;

  localparam int unsigned LBA_W = 20;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             sector_tick;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LBA_W-1:0] cmd_lba;
  logic             fetch_req;
  logic [LBA_W-1:0] fetch_lba;
  logic             fetch_ack;
  logic             sector_irq;
  logic [LBA_W-1:0] cur_lba;
  logic [1:0]       state;
  logic [7:0]       missed;

  int total = 0;
  int bad   = 0;
  logic [LBA_W-1:0] exp_q[$];
  logic irq_due = 1'b0;
  logic irq_was = 1'b0;

`ifdef CDIC_SCHED_STATS_EN
  localparam int unsigned MISS2 = 2;
`else
  localparam int unsigned MISS2 = 0;
`endif

  cdic_sector_scheduler #(.SEEK_TICKS(3), .LBA_W(LBA_W)) dut (
    .clk(clk), .reset_n(reset_n), .sector_tick(sector_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_lba(cmd_lba), .fetch_req(fetch_req), .fetch_lba(fetch_lba),
    .fetch_ack(fetch_ack), .sector_irq(sector_irq), .cur_lba(cur_lba),
    .state(state), .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: accepted fetch -> pop and compare address; irq exactly one cycle later.
  always @(negedge clk) begin
    if (irq_due) chk("irq_pulse", 32'(sector_irq), 32'd1);
    else if (irq_was) chk("irq_single", 32'(sector_irq), 32'd0);
    irq_was = irq_due;
    irq_due = reset_n && fetch_req && fetch_ack;
    if (irq_due) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fetch", 32'(fetch_lba), 32'hFFFF_FFFF);
      end else begin
        chk("sb_fetch_lba", 32'(fetch_lba), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [LBA_W-1:0] lba, input logic with_tick);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_lba     = lba;
    sector_tick = with_tick;
    cyc();
    cmd_valid   = 1'b0;
    sector_tick = 1'b0;
  endtask

  task automatic tick();
    sector_tick = 1'b1;
    cyc();
    sector_tick = 1'b0;
  endtask

  task automatic ack();
    fetch_ack = 1'b1;
    cyc();
    fetch_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sector_tick = 1'b0; fetch_ack = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_lba = 20'd55;
    cyc();
    chk("ready_in_reset", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cur_lba", 32'(cur_lba), 32'd0);
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_missed", 32'(missed), 32'd0);

    // SEEK 100, three ticks to PLAYING, fourth tick fetches 100
    send_cmd(2'd2, 20'd100, 1'b0);
    chk("seek_state", 32'(state), 32'd1);
    chk("seek_cur", 32'(cur_lba), 32'd100);
    tick();
    tick();
    chk("seek_t2_state", 32'(state), 32'd1);
    tick();
    chk("seek_t3_state", 32'(state), 32'd2);
    chk("seek_t3_noreq", 32'(fetch_req), 32'd0);
    exp_q.push_back(20'd100);
    tick();
    chk("t4_req", 32'(fetch_req), 32'd1);
    chk("t4_lba", 32'(fetch_lba), 32'd100);
    chk("t4_cur", 32'(cur_lba), 32'd101);

    // two overrun ticks while the request is unacknowledged
    tick();
    tick();
    chk("ovr_lba_held", 32'(fetch_lba), 32'd100);
    chk("ovr_req_held", 32'(fetch_req), 32'd1);
    chk("ovr_cur", 32'(cur_lba), 32'd103);
    chk("ovr_missed", 32'(missed), 32'(MISS2));
    ack();
    chk("ack_req_drop", 32'(fetch_req), 32'd0);
    chk("ack_irq", 32'(sector_irq), 32'd1);
    cyc();
    chk("ack_irq_low", 32'(sector_irq), 32'd0);

    // ack coincident with tick is not an overrun
    exp_q.push_back(20'd103);
    tick();
    chk("co_lba0", 32'(fetch_lba), 32'd103);
    exp_q.push_back(20'd104);
    fetch_ack = 1'b1; sector_tick = 1'b1;
    cyc();
    fetch_ack = 1'b0; sector_tick = 1'b0;
    chk("co_req", 32'(fetch_req), 32'd1);
    chk("co_lba1", 32'(fetch_lba), 32'd104);
    chk("co_cur", 32'(cur_lba), 32'd105);
    chk("co_missed", 32'(missed), 32'(MISS2));
    ack();

    // PAUSE with request outstanding; PLAY coincident with tick ignores the tick
    exp_q.push_back(20'd105);
    tick();
    send_cmd(2'd3, 20'd0, 1'b0);
    chk("pause_state", 32'(state), 32'd3);
    chk("pause_req_held", 32'(fetch_req), 32'd1);
    tick();
    chk("pause_cur", 32'(cur_lba), 32'd106);
    chk("pause_lba_held", 32'(fetch_lba), 32'd105);
    ack();
    tick();
    chk("pause_no_req", 32'(fetch_req), 32'd0);
    send_cmd(2'd1, 20'd0, 1'b1);
    chk("play_state", 32'(state), 32'd2);
    chk("play_tick_ignored", 32'(fetch_req), 32'd0);
    chk("play_cur", 32'(cur_lba), 32'd106);
    exp_q.push_back(20'd106);
    tick();
    chk("resume_lba", 32'(fetch_lba), 32'd106);
    ack();

    // address wrap at the top of the LBA space
    send_cmd(2'd2, 20'hFFFFF, 1'b0);
    tick(); tick(); tick();
    exp_q.push_back(20'hFFFFF);
    tick();
    chk("wrap_lba", 32'(fetch_lba), 32'hFFFFF);
    chk("wrap_cur", 32'(cur_lba), 32'd0);
    ack();
    send_cmd(2'd0, 20'd0, 1'b0);
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_cur", 32'(cur_lba), 32'd0);

    // reset mid-fetch drops the request
    send_cmd(2'd1, 20'd0, 1'b0);
    exp_q.push_back(20'd0);
    tick();
    chk("pre_rst_req", 32'(fetch_req), 32'd1);
    exp_q.delete();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("mid_rst_req", 32'(fetch_req), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_missed", 32'(missed), 32'd0);
    chk("mid_rst_cur", 32'(cur_lba), 32'd0);

    cyc(); cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdic_sector_scheduler.md
CDIC_SECTOR_SCHEDULER -- requirements
Module: cdic_sector_scheduler

Interface
REQ-001 SHALL have parameter SEEK_TICKS, default 3: number of sector ticks a seek takes before play starts (range 1..15).
REQ-002 SHALL have parameter LBA_W, default 20: width of the sector address.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port sector_tick, input, 1: single-cycle pulse at the 75 Hz sector rate, already in the clk domain.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_op, input, 2: 0=STOP, 1=PLAY, 2=SEEK, 3=PAUSE.
REQ-009 SHALL have port cmd_lba, input, LBA_W: target sector for SEEK; ignored for the other ops.
REQ-010 SHALL have port fetch_req, output, 1: sector fetch request.
REQ-011 SHALL have port fetch_lba, output, LBA_W: sector to fetch; stable while fetch_req is high.
REQ-012 SHALL have port fetch_ack, input, 1: fetch accepted when fetch_req and fetch_ack are both high.
REQ-013 SHALL have port sector_irq, output, 1: single-cycle pulse, one cycle after each accepted fetch.
REQ-014 SHALL have port cur_lba, output, LBA_W: next sector to be fetched.
REQ-015 SHALL have port state, output, 2: current state, encoded 0=IDLE, 1=SEEKING, 2=PLAYING, 3=PAUSED.
REQ-016 SHALL have port missed, output, 8: saturating count of sectors lost to overrun.

Function
REQ-017 SHALL hold cmd_ready high in every state, so each command is accepted in one cycle.
REQ-018 SHALL handle STOP by entering IDLE from any state; cur_lba is unchanged.
REQ-019 SHALL handle SEEK by loading cur_lba from cmd_lba, loading the seek counter with SEEK_TICKS and entering SEEKING, from any state.
REQ-020 SHALL decrement the seek counter on each sector_tick in SEEKING; the tick that reaches 0 moves to PLAYING and issues no fetch.
REQ-021 SHALL handle PLAY by moving IDLE or PAUSED to PLAYING; PLAY in SEEKING or PLAYING is a no-op.
REQ-022 SHALL handle PAUSE by moving PLAYING to PAUSED; PAUSE in other states is a no-op.
REQ-023 SHALL, on sector_tick in PLAYING with no fetch outstanding, raise fetch_req on the next cycle with fetch_lba = cur_lba and increment cur_lba.
REQ-024 SHALL keep fetch_req and fetch_lba held until fetch_ack, regardless of state changes; a request is never withdrawn.
REQ-025 SHALL treat a sector_tick in PLAYING while fetch_req is high and fetch_ack is low as an overrun: no new request, cur_lba still increments, missed increments and saturates at 255.
REQ-026 SHALL treat fetch_ack and sector_tick in the same cycle as not an overrun: the new fetch_req is raised on the next cycle.
REQ-027 SHALL process an accepted command in the same cycle as a sector_tick and ignore that tick.
REQ-028 SHALL wrap cur_lba from 2^LBA_W-1 to 0.

Reset
REQ-029 SHALL, while reset_n is low at a clk edge, set state=IDLE, cur_lba=0, seek counter=0, fetch_req=0, fetch_lba=0, sector_irq=0, missed=0.
REQ-030 SHALL drop an outstanding fetch_req on reset; this is the only exception to REQ-024.
REQ-031 SHALL hold cmd_ready high during reset, but commands offered while reset_n is low have no effect.

Configuration
REQ-032 SHALL, with macro CDIC_SCHED_STATS_EN defined, implement the missed counter as in REQ-025.
REQ-033 SHALL, without CDIC_SCHED_STATS_EN, tie missed to 0 and implement no counter logic; overrun behaviour is otherwise identical.

Verification
REQ-034 SHALL cover: SEEK lba=100, 3 ticks -> state SEEKING, then PLAYING on tick 3; tick 4 -> fetch_req with fetch_lba=100, cur_lba=101.
REQ-035 SHALL cover: PLAYING with fetch_ack held low across 2 ticks -> fetch_lba stays 100, missed=2, cur_lba=103; then ack -> sector_irq pulses for 1 cycle.
REQ-036 SHALL cover: fetch_ack coincident with sector_tick -> missed unchanged, next fetch_req one cycle later.
REQ-037 SHALL cover: cur_lba=0xFFFFF in PLAYING, tick and ack -> fetch_lba=0xFFFFF, cur_lba=0.
REQ-038 SHALL cover: PAUSE during an outstanding request -> fetch_req held until ack, then no further requests; PLAY -> fetching resumes at cur_lba.
REQ-039 SHALL cover: reset_n low for 1 cycle mid-fetch -> fetch_req=0, state=IDLE, missed=0 on the next cycle.
